// File: rtl/parking_pkg.sv
// Shared constants and state encoding for the parking gate controller.
package parking_pkg;

  localparam int NUM_SLOTS   = 8;
  localparam int SLOT_W      = 3;
  localparam int CNT_W       = 4;
  localparam int GATE_CYCLES = 4;
  // Wide enough for the largest legal GATE_CYCLES value (255).
  localparam int GATE_CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-zero-bit priority encoder over the occupancy bitmap.
module free_slot_finder #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
) (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W-1:0]    slot,
  output logic                 found
);

  // Scan downward so the last hit, the lowest free index, wins.
  always_comb begin
    slot  = '0;
    found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        slot  = SLOT_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit arbitration, slot allocation, occupancy tracking and gate timing.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS   = parking_pkg::NUM_SLOTS,
  parameter int SLOT_W      = parking_pkg::SLOT_W,
  parameter int CNT_W       = parking_pkg::CNT_W,
  parameter int GATE_CYCLES = parking_pkg::GATE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 entry_grant,
  output logic                 exit_grant,
  output logic [SLOT_W-1:0]    assigned_slot,
  output logic                 entry_reject,
  output logic                 exit_err,
  output logic                 gate_open,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0]     parked,
  output logic                 full,
  output logic                 empty,
  output state_t               state_dbg
);

  // Handshake: entry_req/exit_req are levels held by the requester until a
  // one-cycle grant/reject/err pulse answers them; requests seen in GATE are
  // ignored and re-evaluated on the first IDLE cycle.

  state_t                 state_q, state_d;
  logic [GATE_CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0]   occ_d;
  logic [CNT_W-1:0]       parked_d;
  logic [SLOT_W-1:0]      slot_d;
  logic [SLOT_W-1:0]      free_slot;
  logic                   free_found;
  logic                   eg_d, xg_d, er_d, xe_d, go_d;

  free_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_finder (
    .occupancy (occupancy),
    .slot      (free_slot),
    .found     (free_found)
  );

  assign full      = (parked == CNT_W'(NUM_SLOTS));
  assign empty     = (parked == '0);
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    occ_d    = occupancy;
    parked_d = parked;
    slot_d   = assigned_slot;
    eg_d     = 1'b0;
    xg_d     = 1'b0;
    er_d     = 1'b0;
    xe_d     = 1'b0;
    go_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Exit has priority so a departing car never waits behind an arrival.
        if (exit_req) begin
          if (occupancy[exit_slot]) begin
            occ_d[exit_slot] = 1'b0;
            parked_d         = parked - CNT_W'(1);
            xg_d             = 1'b1;
            go_d             = 1'b1;
            cnt_d            = GATE_CNT_W'(GATE_CYCLES - 1);
            state_d          = GATE;
          end else begin
            xe_d = 1'b1;
          end
        end else if (entry_req) begin
          if (!full && free_found) begin
            occ_d[free_slot] = 1'b1;
            slot_d           = free_slot;
            parked_d         = parked + CNT_W'(1);
            eg_d             = 1'b1;
            go_d             = 1'b1;
            cnt_d            = GATE_CNT_W'(GATE_CYCLES - 1);
            state_d          = GATE;
          end else begin
            er_d = 1'b1;
          end
        end
      end
      GATE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - GATE_CNT_W'(1);
          go_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      occupancy     <= '0;
      parked        <= '0;
      assigned_slot <= '0;
      entry_grant   <= 1'b0;
      exit_grant    <= 1'b0;
      entry_reject  <= 1'b0;
      exit_err      <= 1'b0;
      gate_open     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      occupancy     <= occ_d;
      parked        <= parked_d;
      assigned_slot <= slot_d;
      entry_grant   <= eg_d;
      exit_grant    <= xg_d;
      entry_reject  <= er_d;
      exit_err      <= xe_d;
      gate_open     <= go_d;
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Table-driven bench for parking_gate_controller with a hand-written async reset sequence.
module tb_parking_gate_controller;
  import parking_pkg::*;

  typedef struct packed {
    logic       eg;
    logic       xg;
    logic       er;
    logic       xe;
    logic       go;
    logic [2:0] as;
    logic [7:0] occ;
    logic [3:0] pk;
    logic       full;
    logic       empty;
    state_t     st;
  } out_t;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic       ex;
    logic [2:0] slot;
    out_t       exp;
  } vec_t;

  // Clock/reset and DUT signals
  logic       clk = 1'b0;
  logic       rst_n;
  logic       entry_req, exit_req;
  logic [2:0] exit_slot;
  logic       entry_grant, exit_grant, entry_reject, exit_err, gate_open;
  logic [2:0] assigned_slot;
  logic [7:0] occupancy;
  logic [3:0] parked;
  logic       full, empty;
  state_t     state_dbg;

  always #5 clk = ~clk;

  parking_gate_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .exit_slot     (exit_slot),
    .entry_grant   (entry_grant),
    .exit_grant    (exit_grant),
    .assigned_slot (assigned_slot),
    .entry_reject  (entry_reject),
    .exit_err      (exit_err),
    .gate_open     (gate_open),
    .occupancy     (occupancy),
    .parked        (parked),
    .full          (full),
    .empty         (empty),
    .state_dbg     (state_dbg)
  );

  // Scoreboard
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic out_t mk(bit eg, bit xg, bit er, bit xe, bit go, int as,
                              logic [7:0] occ, int pk, state_t st);
    out_t o;
    o.eg    = eg;
    o.xg    = xg;
    o.er    = er;
    o.xe    = xe;
    o.go    = go;
    o.as    = 3'(as);
    o.occ   = occ;
    o.pk    = 4'(pk);
    o.full  = (pk == 8);
    o.empty = (pk == 0);
    o.st    = st;
    return o;
  endfunction

  function automatic void add(bit r, bit en, bit ex, int slot, out_t e);
    vec_t v;
    v.rst_n = r;
    v.en    = en;
    v.ex    = ex;
    v.slot  = 3'(slot);
    v.exp   = e;
    tbl.push_back(v);
  endfunction

  // Three more open cycles after the grant cycle, then one closing cycle.
  function automatic void add_gate(bit en, bit ex, int slot, int as, logic [7:0] occ, int pk);
    for (int c = 0; c < 3; c++)
      add(1, en, ex, slot, mk(0, 0, 0, 0, 1, as, occ, pk, GATE));
    add(1, en, ex, slot, mk(0, 0, 0, 0, 0, as, occ, pk, IDLE));
  endfunction

  task automatic check(input string name, input out_t e);
    out_t a;
    a = '{entry_grant, exit_grant, entry_reject, exit_err, gate_open, assigned_slot,
          occupancy, parked, full, empty, state_dbg};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got eg=%b xg=%b er=%b xe=%b go=%b as=%0d occ=%b pk=%0d full=%b empty=%b st=%0d | expected eg=%b xg=%b er=%b xe=%b go=%b as=%0d occ=%b pk=%0d full=%b empty=%b st=%0d",
               name, a.eg, a.xg, a.er, a.xe, a.go, a.as, a.occ, a.pk, a.full, a.empty, a.st,
               e.eg, e.xg, e.er, e.xe, e.go, e.as, e.occ, e.pk, e.full, e.empty, e.st);
    end
  endtask

  initial begin
    logic [7:0] occ;
    rst_n     = 1'b0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = '0;

    // Reset values
    add(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 8'h00, 0, IDLE));
    add(0, 1, 1, 0, mk(0, 0, 0, 0, 0, 0, 8'h00, 0, IDLE));
    add(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 8'h00, 0, IDLE));
    // Single-cycle entry request; exit requests during the gate are ignored
    add(1, 1, 0, 0, mk(1, 0, 0, 0, 1, 0, 8'h01, 1, GATE));
    add_gate(0, 1, 5, 0, 8'h01, 1);
    // Held entry request is served again as soon as the gate closes
    add(1, 1, 0, 0, mk(1, 0, 0, 0, 1, 1, 8'h03, 2, GATE));
    add_gate(1, 0, 0, 1, 8'h03, 2);
    // Exit of an empty slot: repeated errors, exit still outranks entry
    add(1, 0, 1, 5, mk(0, 0, 0, 1, 0, 1, 8'h03, 2, IDLE));
    add(1, 0, 1, 5, mk(0, 0, 0, 1, 0, 1, 8'h03, 2, IDLE));
    add(1, 1, 1, 5, mk(0, 0, 0, 1, 0, 1, 8'h03, 2, IDLE));
    // Fill the remaining slots in order
    for (int k = 2; k < 8; k++) begin
      occ = 8'((1 << (k + 1)) - 1);
      add(1, 1, 0, 0, mk(1, 0, 0, 0, 1, k, occ, k + 1, GATE));
      add_gate(1, 0, 0, k, occ, k + 1);
    end
    // Full lot: repeated rejects, no gate
    add(1, 1, 0, 0, mk(0, 0, 1, 0, 0, 7, 8'hFF, 8, IDLE));
    add(1, 1, 0, 0, mk(0, 0, 1, 0, 0, 7, 8'hFF, 8, IDLE));
    add(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 7, 8'hFF, 8, IDLE));
    // Exit slot 3, then the next entry reuses it
    add(1, 0, 1, 3, mk(0, 1, 0, 0, 1, 7, 8'hF7, 7, GATE));
    add_gate(0, 0, 0, 7, 8'hF7, 7);
    add(1, 1, 0, 0, mk(1, 0, 0, 0, 1, 3, 8'hFF, 8, GATE));
    add_gate(0, 0, 0, 3, 8'hFF, 8);
    // Simultaneous entry and exit: exit first, entry after gate + 1 cycle
    add(1, 1, 1, 0, mk(0, 1, 0, 0, 1, 3, 8'hFE, 7, GATE));
    add_gate(1, 0, 0, 3, 8'hFE, 7);
    add(1, 1, 0, 0, mk(1, 0, 0, 0, 1, 0, 8'hFF, 8, GATE));
    add_gate(0, 0, 0, 0, 8'hFF, 8);

    foreach (tbl[i]) begin
      rst_n     = tbl[i].rst_n;
      entry_req = tbl[i].en;
      exit_req  = tbl[i].ex;
      exit_slot = tbl[i].slot;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Asynchronous reset during the second gate cycle
    entry_req = 1'b0;
    exit_req  = 1'b1;
    exit_slot = 3'd2;
    @(posedge clk);
    #1;
    check("rst_exit", mk(0, 1, 0, 0, 1, 0, 8'hFB, 7, GATE));
    exit_req = 1'b0;
    @(posedge clk);
    #1;
    check("rst_gate2", mk(0, 0, 0, 0, 1, 0, 8'hFB, 7, GATE));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", mk(0, 0, 0, 0, 0, 0, 8'h00, 0, IDLE));
    @(negedge clk);
    rst_n     = 1'b1;
    entry_req = 1'b1;
    @(posedge clk);
    #1;
    check("rst_entry", mk(1, 0, 0, 0, 1, 0, 8'h01, 1, GATE));
    entry_req = 1'b0;
    @(posedge clk);
    #1;
    check("rst_entry_gate", mk(0, 0, 0, 0, 1, 0, 8'h01, 1, GATE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
